// File: rtl/free_list_pkg.sv
// Shared rename-stage types for the physical-register free list, RAT and ROB.
// Pointers carry one extra wrap bit above the register index width.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif

package free_list_pkg;

  localparam int FL_PHY_REG_NUM  = 64;
  localparam int FL_ARCH_REG_NUM = 32;
  localparam int FL_DECODE_WIDTH = `DECODE_WIDTH;
  localparam int FL_PREG_W       = $clog2(FL_PHY_REG_NUM);
  localparam int FL_PTR_W        = FL_PREG_W + 1;
  localparam int FL_INIT_COUNT   = FL_PHY_REG_NUM - FL_ARCH_REG_NUM;

  typedef logic [FL_PREG_W-1:0] preg_t;
  typedef logic [FL_PTR_W-1:0]  fl_ptr_t;

  // Width needed to hold a population count of an n-bit vector.
  function automatic int fl_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/commit side bundle of the free list: allocate request/grant,
// commit-time frees, flush restore and the free-entry count.
interface free_list_if
  import free_list_pkg::*;
#(
  parameter int ALLOC_WIDTH = FL_DECODE_WIDTH,
  parameter int FREE_WIDTH  = FL_DECODE_WIDTH,
  parameter int PHY_REG_NUM = FL_PHY_REG_NUM
);

  localparam int PW    = $clog2(PHY_REG_NUM);
  localparam int CNT_W = PW + 1;

  logic                             alloc_valid_i;
  logic [ALLOC_WIDTH-1:0]           alloc_req_i;
  logic                             alloc_ready_o;
  logic [ALLOC_WIDTH-1:0][PW-1:0]   preg_o;
  logic [FREE_WIDTH-1:0]            free_i;
  logic [FREE_WIDTH-1:0][PW-1:0]    old_preg_i;
  logic                             restore_i;
  logic [CNT_W-1:0]                 free_count_o;

  modport master (
    output alloc_valid_i, alloc_req_i, free_i, old_preg_i, restore_i,
    input  alloc_ready_o, preg_o, free_count_o
  );

  modport slave (
    input  alloc_valid_i, alloc_req_i, free_i, old_preg_i, restore_i,
    output alloc_ready_o, preg_o, free_count_o
  );

endinterface

// File: rtl/prefix_popcount.sv
// Exclusive prefix population count of an N-bit vector plus its total:
// o_prefix[i] is the number of set bits strictly below bit i.
module prefix_popcount
  import free_list_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = fl_cnt_width(N)
) (
  input  logic [N-1:0]         i_vec,
  output logic [N-1:0][CW-1:0] o_prefix,
  output logic [CW-1:0]        o_total
);

  logic [CW-1:0] w_acc;

  always_comb begin
    w_acc    = '0;
    o_prefix = '0;
    for (int i = 0; i < N; i++) begin
      o_prefix[i] = w_acc;
      w_acc       = w_acc + CW'(i_vec[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical register indices: multi-lane allocate at head,
// multi-lane reclaim at tail, and flush recovery from the committed head.
module free_list
  import free_list_pkg::*;
#(
  parameter int PHY_REG_NUM  = FL_PHY_REG_NUM,
  parameter int ARCH_REG_NUM = FL_ARCH_REG_NUM,
  parameter int ALLOC_WIDTH  = FL_DECODE_WIDTH,
  parameter int FREE_WIDTH   = FL_DECODE_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  free_list_if.slave  bus
);

  localparam int PW         = $clog2(PHY_REG_NUM);
  localparam int TW         = PW + 1;
  localparam int XW         = TW + 1;
  localparam int ACW        = fl_cnt_width(ALLOC_WIDTH);
  localparam int FCW        = fl_cnt_width(FREE_WIDTH);
  localparam int INIT_COUNT = PHY_REG_NUM - ARCH_REG_NUM;

  logic [PW-1:0]                  r_slot [PHY_REG_NUM];
  logic [TW-1:0]                  r_head;
  logic [TW-1:0]                  r_tail;
  logic [TW-1:0]                  r_arch_head;

  logic [ALLOC_WIDTH-1:0][ACW-1:0] w_alloc_pre;
  logic [ACW-1:0]                  w_alloc_n;
  logic [FREE_WIDTH-1:0][FCW-1:0]  w_free_pre;
  logic [FCW-1:0]                  w_free_n;
  logic [ALLOC_WIDTH-1:0][PW-1:0]  w_rd_idx;
  logic [FREE_WIDTH-1:0][PW-1:0]   w_wr_idx;
  logic [TW-1:0]                   w_count;
  logic                            w_fire;

  prefix_popcount #(.N(ALLOC_WIDTH), .CW(ACW)) u_alloc_cnt (
    .i_vec    (bus.alloc_req_i),
    .o_prefix (w_alloc_pre),
    .o_total  (w_alloc_n)
  );

  prefix_popcount #(.N(FREE_WIDTH), .CW(FCW)) u_free_cnt (
    .i_vec    (bus.free_i),
    .o_prefix (w_free_pre),
    .o_total  (w_free_n)
  );

  assign w_count          = r_tail - r_head;
  assign bus.free_count_o = w_count;
  assign bus.alloc_ready_o = (w_count >= TW'(w_alloc_n));
  assign w_fire           = bus.alloc_valid_i & bus.alloc_ready_o & ~bus.restore_i;

  // Index arithmetic drops the wrap bit so slot addresses wrap modulo PHY_REG_NUM.
  generate
    for (genvar gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_rd
      assign w_rd_idx[gi]   = r_head[PW-1:0] + PW'(w_alloc_pre[gi]);
      assign bus.preg_o[gi] = r_slot[w_rd_idx[gi]];
    end
    for (genvar gi = 0; gi < FREE_WIDTH; gi++) begin : g_wr
      assign w_wr_idx[gi] = r_tail[PW-1:0] + PW'(w_free_pre[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        r_slot[i] <= PW'(i + ARCH_REG_NUM);
      end
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= TW'(INIT_COUNT);
    end else begin
      for (int j = 0; j < FREE_WIDTH; j++) begin
        if (bus.free_i[j]) begin
          r_slot[w_wr_idx[j]] <= bus.old_preg_i[j];
        end
      end
      r_tail      <= r_tail + TW'(w_free_n);
      r_arch_head <= r_arch_head + TW'(w_free_n);
      // Same-cycle commits advance the committed head before it is restored.
      if (bus.restore_i) begin
        r_head <= r_arch_head + TW'(w_free_n);
      end else if (w_fire) begin
        r_head <= r_head + TW'(w_alloc_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (XW'(w_count) + XW'(w_free_n) <= XW'(PHY_REG_NUM));
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based reference model, scoreboard of
// expected allocations, a vector table and hand-written corner sequences.
module tb_free_list;
  import free_list_pkg::*;

  localparam int AW  = 4;
  localparam int FW  = 4;
  localparam int PRN = 64;
  localparam int ARN = 32;
  localparam int PW  = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  free_list_if #(.ALLOC_WIDTH(AW), .FREE_WIDTH(FW), .PHY_REG_NUM(PRN)) fl_if ();

  free_list #(
    .PHY_REG_NUM  (PRN),
    .ARCH_REG_NUM (ARN),
    .ALLOC_WIDTH  (AW),
    .FREE_WIDTH   (FW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fl_if.slave)
  );

  typedef struct {
    logic       valid;
    logic [3:0] req;
    logic [3:0] fm;
    logic       rq;
    logic       exp_ready;
    int         exp_count;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_free[$];
  int   uncommitted[$];
  int   held_q[$];
  int   sb_q[$];
  int   freed_q[$];
  logic pend_restore;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int popc4(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int in_held(input int v);
    foreach (held_q[i]) if (held_q[i] == v) return 1;
    return 0;
  endfunction

  task automatic held_remove(input int v);
    for (int i = 0; i < held_q.size(); i++) begin
      if (held_q[i] == v) begin
        held_q.delete(i);
        break;
      end
    end
  endtask

  task automatic model_reset();
    model_free.delete();
    uncommitted.delete();
    held_q.delete();
    sb_q.delete();
    freed_q.delete();
    pend_restore = 1'b0;
    for (int i = ARN; i < PRN; i++) model_free.push_back(i);
    for (int i = 0; i < ARN; i++) held_q.push_back(i);
  endtask

  task automatic idle_inputs();
    fl_if.alloc_valid_i = 1'b0;
    fl_if.alloc_req_i   = '0;
    fl_if.free_i        = '0;
    fl_if.old_preg_i    = '0;
    fl_if.restore_i     = 1'b0;
  endtask

  // Drive one cycle's inputs, check ready and scoreboard the allocated lanes.
  task automatic drive(input logic valid, input logic [3:0] req,
                       input logic [3:0] fm, input logic rq);
    int   n;
    int   e;
    logic exp_ready;
    fl_if.alloc_valid_i = valid;
    fl_if.alloc_req_i   = req;
    fl_if.free_i        = fm;
    fl_if.restore_i     = rq;
    freed_q.delete();
    for (int j = 0; j < FW; j++) begin
      if (fm[j] && held_q.size() > 0) begin
        e = held_q.pop_front();
        fl_if.old_preg_i[j] = PW'(e);
        freed_q.push_back(e);
      end else begin
        fl_if.old_preg_i[j] = '0;
      end
    end
    pend_restore = rq;
    #1;
    n = popc4(req);
    exp_ready = (model_free.size() >= n);
    chk("alloc_ready", int'(fl_if.alloc_ready_o), int'(exp_ready));
    if (valid && exp_ready && !rq) begin
      for (int i = 0; i < AW; i++) if (req[i]) sb_q.push_back(model_free.pop_front());
      for (int i = 0; i < AW; i++) begin
        if (req[i]) begin
          e = sb_q.pop_front();
          chk($sformatf("preg_lane%0d", i), int'(fl_if.preg_o[i]), e);
          chk("dup_outstanding", in_held(int'(fl_if.preg_o[i])), 0);
          held_q.push_back(e);
          uncommitted.push_back(e);
        end
      end
    end
  endtask

  // Apply this cycle's frees/restore to the model, take the edge, check count.
  task automatic edge_step();
    for (int k = 0; k < freed_q.size(); k++) begin
      if (uncommitted.size() > 0) void'(uncommitted.pop_front());
    end
    if (pend_restore) begin
      for (int k = uncommitted.size() - 1; k >= 0; k--) begin
        model_free.push_front(uncommitted[k]);
        held_remove(uncommitted[k]);
      end
      uncommitted.delete();
    end
    foreach (freed_q[k]) model_free.push_back(freed_q[k]);
    @(posedge clk);
    #1;
    chk("free_count", int'(fl_if.free_count_o), model_free.size());
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 28};
    tbl[1] = '{1'b1, 4'b1010, 4'b0000, 1'b0, 1'b1, 26};
    tbl[2] = '{1'b0, 4'b1111, 4'b0011, 1'b0, 1'b1, 28};
    tbl[3] = '{1'b1, 4'b0001, 4'b1111, 1'b0, 1'b1, 31};
    tbl[4] = '{1'b1, 4'b1111, 4'b0001, 1'b0, 1'b1, 28};
    tbl[5] = '{1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 32};
    tbl[6] = '{1'b1, 4'b0110, 4'b0000, 1'b0, 1'b1, 30};
    tbl[7] = '{1'b0, 4'b0000, 4'b0011, 1'b1, 1'b1, 32};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset image
    chk("rst_free_count", int'(fl_if.free_count_o), 32);
    fl_if.alloc_req_i = 4'b1111;
    #1;
    chk("rst_ready", int'(fl_if.alloc_ready_o), 1);
    for (int i = 0; i < AW; i++) chk($sformatf("rst_preg%0d", i), int'(fl_if.preg_o[i]), 32 + i);

    // Vector table from the reset state
    for (int v = 0; v < 8; v++) begin
      drive(tbl[v].valid, tbl[v].req, tbl[v].fm, tbl[v].rq);
      chk($sformatf("tbl%0d_ready", v), int'(fl_if.alloc_ready_o), int'(tbl[v].exp_ready));
      edge_step();
      chk($sformatf("tbl%0d_count", v), int'(fl_if.free_count_o), tbl[v].exp_count);
    end

    // Drain to one entry, stall a two-lane group, then recover via frees
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 4'b1111, 4'b0000, 1'b0);
      edge_step();
    end
    drive(1'b1, 4'b0111, 4'b0000, 1'b0);
    edge_step();
    chk("drain_count", int'(fl_if.free_count_o), 1);
    drive(1'b1, 4'b0011, 4'b0000, 1'b0);
    chk("stall_ready", int'(fl_if.alloc_ready_o), 0);
    edge_step();
    chk("stall_count", int'(fl_if.free_count_o), 1);
    drive(1'b1, 4'b0011, 4'b0111, 1'b0);
    chk("stall_free_ready", int'(fl_if.alloc_ready_o), 0);
    edge_step();
    chk("after_free_count", int'(fl_if.free_count_o), 4);
    drive(1'b1, 4'b0011, 4'b0000, 1'b0);
    chk("after_free_ready", int'(fl_if.alloc_ready_o), 1);
    edge_step();

    // Restore without and with same-cycle commits
    do_reset();
    drive(1'b1, 4'b1111, 4'b0000, 1'b0);
    edge_step();
    drive(1'b1, 4'b1111, 4'b0000, 1'b0);
    edge_step();
    drive(1'b0, 4'b0000, 4'b0000, 1'b1);
    edge_step();
    chk("restore_count", int'(fl_if.free_count_o), 32);
    drive(1'b1, 4'b0001, 4'b0000, 1'b0);
    chk("restore_oldest", int'(fl_if.preg_o[0]), 32);
    edge_step();
    drive(1'b1, 4'b1111, 4'b0000, 1'b0);
    edge_step();
    drive(1'b0, 4'b0000, 4'b0011, 1'b1);
    edge_step();
    // Restored count is tail - arch_head; commits move both, so it stays 32.
    chk("restore_free2_count", int'(fl_if.free_count_o), 32);

    // Steady alloc-4/free-4 across several pointer wraps
    do_reset();
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 4'b1111, 4'b1111, 1'b0);
      edge_step();
      chk("wrap_count", int'(fl_if.free_count_o), 32);
    end

    // Reset mid-operation with frees in flight
    fl_if.alloc_valid_i = 1'b1;
    fl_if.alloc_req_i   = 4'b1111;
    fl_if.free_i        = 4'b1111;
    for (int j = 0; j < FW; j++) fl_if.old_preg_i[j] = PW'(j + 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_inputs();
    model_reset();
    chk("midrst_count", int'(fl_if.free_count_o), 32);
    fl_if.alloc_req_i = 4'b1111;
    #1;
    chk("midrst_ready", int'(fl_if.alloc_ready_o), 1);
    for (int i = 0; i < AW; i++) chk($sformatf("midrst_preg%0d", i), int'(fl_if.preg_o[i]), 32 + i);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0);
    edge_step();
    chk("midrst_alloc_count", int'(fl_if.free_count_o), 28);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
